// File: rtl/nx_indirect_access_table.sv
// nx_indirect_access_table
//
// Flop-based table that answers the indirect access controller and also serves a
// datapath read port. The software side and the datapath side share one
// combinational arbiter. Software wins over the datapath only while `yield` is high.
//
// Optional feature macro: NX_IA_TABLE_COMPARE_EN
//   When defined, the table builds per-entry valid bits and a two-stage compare
//   pipeline. When undefined, sw_match and sw_aindex are tied to 0. A compare is
//   still granted in that case, but it does nothing.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   sw_cs/ce/we           controller request, compare and write qualifiers
//   sw_add, sw_wdat       software address, write data / compare key
//   reset                 controller init sweep: writes leave entries invalid
//   yield                 controller takes priority over the datapath port
//   grant                 software access accepted (combinational)
//   sw_rdat               read data, valid the cycle after grant
//   sw_match, sw_aindex   compare hit and lowest hit index, valid 2 cycles after grant
//   hw_rd, hw_addr        datapath read request and address
//   hw_gnt                datapath read accepted (combinational)
//   hw_rdata              datapath read data, valid the cycle after hw_gnt
module nx_indirect_access_table #(
  parameter int unsigned N_ENTRIES   = 32,
  parameter int unsigned N_DATA_BITS = 96,
  parameter int unsigned N_ADDR_BITS = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_cs,
  input  logic                   sw_ce,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   reset,
  input  logic                   yield,
  output logic                   grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  output logic                   sw_match,
  output logic [7:0]             sw_aindex,
  input  logic                   hw_rd,
  input  logic [N_ADDR_BITS-1:0] hw_addr,
  output logic                   hw_gnt,
  output logic [N_DATA_BITS-1:0] hw_rdata
);

  localparam int unsigned IdxW = $clog2(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
  logic [N_DATA_BITS-1:0] sw_rdat_q, hw_rdata_q;
  logic [N_DATA_BITS-1:0] sw_mem_rd, hw_mem_rd;
  logic [IdxW-1:0]        sw_idx, hw_idx;
  logic                   sw_in_range, hw_in_range;
  logic                   sw_wr, sw_rd;

  assign grant  = sw_cs & (~hw_rd | yield);
  assign hw_gnt = hw_rd & ~(sw_cs & yield);

  assign sw_in_range = 32'(sw_add) < N_ENTRIES;
  assign hw_in_range = 32'(hw_addr) < N_ENTRIES;
  assign sw_idx      = sw_add[IdxW-1:0];
  assign hw_idx      = hw_addr[IdxW-1:0];

  // Out-of-range reads return 0 instead of aliasing onto a low entry.
  assign sw_mem_rd = sw_in_range ? mem_q[sw_idx] : '0;
  assign hw_mem_rd = hw_in_range ? mem_q[hw_idx] : '0;

  // sw_ce has priority over sw_we, so a compare with sw_we set never writes.
  assign sw_wr = grant & sw_we & ~sw_ce & sw_in_range;
  assign sw_rd = grant & ~sw_we & ~sw_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (sw_wr) begin
      mem_q[sw_idx] <= sw_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rdat_q  <= '0;
      hw_rdata_q <= '0;
    end else begin
      if (sw_rd)  sw_rdat_q  <= sw_mem_rd;
      if (hw_gnt) hw_rdata_q <= hw_mem_rd;
    end
  end

  assign sw_rdat  = sw_rdat_q;
  assign hw_rdata = hw_rdata_q;

`ifdef NX_IA_TABLE_COMPARE_EN
  logic [N_ENTRIES-1:0] valid_q;
  logic [N_ENTRIES-1:0] hit_d, hit_q;
  logic                 sw_cmp;
  logic                 cmp_vld_q;
  logic                 match_q;
  logic [7:0]           aindex_d, aindex_q;

  assign sw_cmp = grant & sw_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (sw_wr) begin
      valid_q[sw_idx] <= ~reset;
    end
  end

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      hit_d[i] = valid_q[i] & (mem_q[i] == sw_wdat);
    end
  end

  // Scan downward so that the lowest set index is the one that sticks.
  always_comb begin
    aindex_d = '0;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (hit_q[i]) aindex_d = 8'(i);
    end
  end

  // Stage 1 captures the hit vector. Stage 2 reduces it. cmp_vld_q tracks
  // which stage-1 contents belong to a real compare, so results hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= '0;
      cmp_vld_q <= 1'b0;
      match_q   <= 1'b0;
      aindex_q  <= '0;
    end else begin
      cmp_vld_q <= sw_cmp;
      if (sw_cmp) hit_q <= hit_d;
      if (cmp_vld_q) begin
        match_q  <= |hit_q;
        aindex_q <= aindex_d;
      end
    end
  end

  assign sw_match  = match_q;
  assign sw_aindex = aindex_q;
`else
  logic unused_reset;
  assign unused_reset = reset;

  assign sw_match  = 1'b0;
  assign sw_aindex = '0;
`endif

endmodule
